// File: rtl/inst_loader.sv
// Program loader: takes a length byte, big-endian 16-bit words and an XOR
// checksum byte from a valid/ready stream and writes the words into instruction memory.
module inst_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t     state;
  logic [8:0] word_num;
  logic [8:0] word_cnt;
  logic [7:0] csum;
  logic       xfer;

  // in_ready is a registered output, so a transfer never depends combinationally on itself
  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_num  <= '0;
      word_cnt  <= '0;
      csum      <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            mem_addr <= '0;
            csum     <= '0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            // A length byte of zero encodes a full 256-word image
            word_num <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            state    <= S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            mem_wdata[DATA_W-1:8] <= in_data;
            csum                  <= csum ^ in_data;
            state                 <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            mem_wdata[7:0] <= in_data;
            csum           <= csum ^ in_data;
            mem_we         <= 1'b1;
            in_ready       <= 1'b0;
            word_cnt       <= word_cnt + 9'd1;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          in_ready <= 1'b1;
          // The address only advances when another word follows, so it never wraps
          if (word_cnt == word_num) begin
            state <= S_CSUM;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            state    <= S_HI;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: memory image captured from the write strobe
// and compared against hand-computed words, addresses, checksums and timing.
module tb_inst_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  inst_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int we_total = 0;
  int rdy_bad = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [15:0] tb_mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture writes mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      tb_mem[mem_addr] = mem_wdata;
      last_addr        = mem_addr;
      we_total         = we_total + 1;
      if (in_ready) rdy_bad = rdy_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Present a byte and hold it until the loader accepts it
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!in_ready) chk("rdy_timeout", 32'(n), 0);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    step($urandom_range(0, 3));
    send_byte(b);
  endtask

  initial begin
    int c0;
    int w0;
    rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    step(2);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we",    32'(mem_we),   0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_hold",  32'(cpu_hold), 0);
    chk("rst_flags", 32'({done, err}), 0);
    rst = 1'b0;
    step(1);

    // Two-word load at full rate
    w0 = we_total;
    pulse_start();
    c0 = cyc;
    chk("len_ready", 32'(in_ready), 1);
    chk("len_hold",  32'(cpu_hold), 1);
    send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h40);
    chk("ok_latency", 32'(cyc - c0), 8);
    chk("ok_done", 32'({done, err}), 'h2);
    chk("ok_hold", 32'(cpu_hold), 0);
    chk("ok_ready", 32'(in_ready), 0);
    chk("ok_w0", 32'(tb_mem[0]), 'h1234);
    chk("ok_w1", 32'(tb_mem[1]), 'hABCD);
    chk("ok_wcnt", 32'(we_total - w0), 2);

    // Bad checksum still writes both words, then err
    tb_mem[0] = 16'h0; tb_mem[1] = 16'h0;
    w0 = we_total;
    pulse_start();
    chk("restart_clr", 32'({done, err}), 0);
    send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h41);
    step(2);
    chk("bad_flags", 32'({done, err}), 'h1);
    chk("bad_hold", 32'(cpu_hold), 1);
    chk("bad_w0", 32'(tb_mem[0]), 'h1234);
    chk("bad_w1", 32'(tb_mem[1]), 'hABCD);
    chk("bad_wcnt", 32'(we_total - w0), 2);
    pulse_start();
    chk("err_clr", 32'({done, err}), 0);
    chk("err_clr_hold", 32'(cpu_hold), 1);
    // Finish that load so the next test starts from DONE
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    chk("one_done", 32'(done), 1);

    // Throttled source with random gaps
    w0 = we_total;
    rdy_bad = 0;
    pulse_start();
    send_gap(8'h03);
    send_gap(8'hDE); send_gap(8'hAD);
    send_gap(8'hBE); send_gap(8'hEF);
    send_gap(8'h55); send_gap(8'hAA);
    send_gap(8'hDD);
    chk("thr_done", 32'({done, err}), 'h2);
    chk("thr_w0", 32'(tb_mem[0]), 'hDEAD);
    chk("thr_w1", 32'(tb_mem[1]), 'hBEEF);
    chk("thr_w2", 32'(tb_mem[2]), 'h55AA);
    chk("thr_wcnt", 32'(we_total - w0), 3);
    chk("thr_rdy_write", 32'(rdy_bad), 0);

    // start during LO must be ignored
    w0 = we_total;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h01);
    start = 1'b1;
    send_byte(8'h02);
    start = 1'b0;
    send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    chk("busy_done", 32'({done, err}), 'h2);
    chk("busy_w0", 32'(tb_mem[0]), 'h0102);
    chk("busy_w1", 32'(tb_mem[1]), 'h0304);
    chk("busy_last", 32'(last_addr), 1);
    chk("busy_wcnt", 32'(we_total - w0), 2);

    // Length byte 0 means 256 words; XOR of {i,~i} pairs over 256 words is 0
    w0 = we_total;
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
    end
    send_byte(8'h00);
    chk("l0_done", 32'({done, err}), 'h2);
    chk("l0_wcnt", 32'(we_total - w0), 256);
    chk("l0_last", 32'(last_addr), 'hFF);
    chk("l0_addr_hold", 32'(mem_addr), 'hFF);
    chk("l0_w0", 32'(tb_mem[0]), 'h00FF);
    chk("l0_w128", 32'(tb_mem[128]), 'h807F);
    chk("l0_w255", 32'(tb_mem[255]), 'hFF00);

    // Reset during the HI phase of word 2
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22);
    step(1);
    chk("mid_hi_ready", 32'(in_ready), 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out", 32'({in_ready, mem_we, cpu_hold, done, err}), 0);
    chk("mid_rst_addr", 32'({mem_addr, mem_wdata}), 0);
    step(1);
    rst = 1'b0;
    step(1);
    w0 = we_total;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h51);
    chk("rl_done", 32'({done, err}), 'h2);
    chk("rl_addr", 32'(last_addr), 0);
    chk("rl_w0", 32'(tb_mem[0]), 'hBEEF);
    chk("rl_wcnt", 32'(we_total - w0), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that writes 16-bit instructions into the writable instruction memory, filling the store that the fetch path later reads through the program counter. It accepts a byte stream over a valid/ready handshake: a length byte, then big-endian instruction words, then an XOR checksum byte. It writes each word with a one-cycle write strobe at consecutive addresses starting at 0. While a load is in progress it holds the CPU stalled and flushed.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width (256 words)
- DATA_W, 16, instruction width; fixed at 16 (two bytes per word)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a load when in IDLE, DONE or ERR; ignored otherwise
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  write data
- cpu_hold  out  1  stall/flush request to the CPU (drives PC load-disable and IR flush)
- done  out  1  level; last load completed with a good checksum
- err  out  1  level; last load failed the checksum

## Operation
- States: IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR with start=1 -> LEN. Clears done, err, the word counter, the address and the checksum accumulator.
- LEN: in_ready=1. On transfer, the byte is stored as the word count N; N=0 means 256. Go to HI.
- HI: in_ready=1. On transfer, the byte is latched as wdata[15:8]. Go to LO.
- LO: in_ready=1. On transfer, the byte is latched as wdata[7:0]. Go to WRITE.
- WRITE: in_ready=0; mem_we=1 for exactly one cycle with the current mem_addr and mem_wdata.
  - If this is word N, go to CSUM.
  - Otherwise increment mem_addr and go to HI.
- CSUM: in_ready=1. On transfer, compare the byte with the accumulator.
  - Equal -> DONE, done=1.
  - Not equal -> ERR, err=1.
- Checksum accumulator: 8-bit XOR of all data bytes (HI and LO). The length byte is excluded. Reset value 0x00.
- Word counter is 9 bits so that N=256 is reachable. mem_addr is ADDR_W bits and never wraps within a load: the last write of a 256-word load is at 0xFF.
- Words already written stay in memory after ERR; no rollback.
- cpu_hold=1 in LEN, HI, LO, WRITE, CSUM and ERR; cpu_hold=0 in IDLE and DONE.
- start while busy (LEN..CSUM) is ignored.
- in_valid with in_ready=0 causes no transfer; the byte must be held by the source.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from in_* to any output except none (in_ready depends on state only).
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0.
- Reset asserted mid-load returns to IDLE immediately. Memory contents are not touched.
- start sampled at cycle t: the state is LEN and in_ready=1 at t+1.
- Full-rate stream: each word costs 3 cycles (HI, LO, WRITE). An N-word load takes 1 + 1 + 3N + 1 cycles from start to DONE.
- The WRITE cycle follows the LO transfer cycle: mem_we is high in cycle t+1 when the LO byte transfers at t.
- done/err assert in the cycle after the CSUM transfer. cpu_hold deasserts in that same cycle on success.

## Test plan
- Reset mid-load: assert rst during the HI phase of word 2 -> all outputs return to reset values asynchronously; the next start reloads from address 0.
- Two-word load at full rate: start, then bytes 0x02, 0x12,0x34, 0xAB,0xCD, checksum 0x12^0x34^0xAB^0xCD=0x40 -> writes 0x1234@0x00 and 0xABCD@0x01, done=1, cpu_hold=0 at start+9.
- Bad checksum: same stream with checksum 0x41 -> err=1, done=0, cpu_hold stays 1; the two words are still written; a new start clears err.
- Length 0: byte 0x00 followed by 256 words -> 256 mem_we pulses, last at mem_addr=0xFF, no address wrap, done=1.
- Throttled source: in_valid toggles every other cycle with random gaps -> identical writes and data; no byte lost or duplicated; in_ready=0 during every WRITE cycle.
- start ignored while busy: pulse start during LO -> no restart; the load completes normally with correct addresses.
